// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding 8-byte request, credit-gated by buffer occupancy.
// Optional performance counters are enabled with the FETCH_CTRL_PERF_EN macro.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_flag,
    input  logic [31:0] branch_pc,
    input  logic        launch_flag1,
    input  logic        launch_flag2,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] fetch_pc,
    output logic [1:0]  issue,
    output logic        stop,
    output logic [2:0]  occupancy
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam logic [4:0] DEPTH_W = BUF_DEPTH[4:0];

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [2:0]  r_occ;
    logic [2:0]  w_occ_nxt;
    logic [2:0]  w_consumed;
    logic [2:0]  w_issued;
    logic [1:0]  w_issue;
    logic [4:0]  w_need_nxt;
    logic        w_resp;
    logic        w_credit;

    function automatic logic [2:0] popcount2(input logic [1:0] v);
        popcount2 = {2'b00, v[0]} + {2'b00, v[1]};
    endfunction

    always_comb begin
        w_consumed = launch_flag2 ? 3'd2 : (launch_flag1 ? 3'd1 : 3'd0);
    end

    // Only a response in WAIT writes the buffer; branch and reset suppress it.
    always_comb begin
        w_resp  = (r_state == S_WAIT) && imem_rvalid;
        w_issue = 2'b00;
        if (w_resp && !branch_flag && !rst) begin
            w_issue = r_pc[2] ? 2'b01 : 2'b11;
        end
        w_issued = popcount2(w_issue);
    end

    always_comb begin
        w_pc_nxt  = r_pc;
        w_occ_nxt = r_occ - w_consumed + w_issued;
        if (branch_flag) begin
            w_pc_nxt  = branch_pc;
            w_occ_nxt = 3'd0;
        end else if (w_issue != 2'b00) begin
            w_pc_nxt = {r_pc[31:3] + 29'd1, 3'b000};
        end
    end

    // Credit is judged on the state the buffer will be in next cycle, so consumption
    // and data written this cycle both count before the next request is allowed.
    always_comb begin
        w_need_nxt = w_pc_nxt[2] ? 5'd1 : 5'd2;
        w_credit   = ({2'b00, w_occ_nxt} + w_need_nxt) <= DEPTH_W;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = (branch_flag || w_credit) ? S_REQ : S_HOLD;
            S_REQ: begin
                if (branch_flag) begin
                    w_state_nxt = imem_ready ? S_DRAIN : S_REQ;
                end else if (imem_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (branch_flag) begin
                    w_state_nxt = imem_rvalid ? S_REQ : S_DRAIN;
                end else if (imem_rvalid) begin
                    w_state_nxt = w_credit ? S_REQ : S_HOLD;
                end
            end
            S_HOLD:  w_state_nxt = (branch_flag || w_credit) ? S_REQ : S_HOLD;
            S_DRAIN: begin
                if (!branch_flag && imem_rvalid) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_occ   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_occ   <= w_occ_nxt;
        end
    end

    always_comb begin
        imem_req  = (r_state == S_REQ) && !rst;
        imem_addr = {r_pc[31:3], 3'b000};
        fetch_pc  = r_pc;
        issue     = w_issue;
        stop      = (r_state == S_HOLD);
        occupancy = r_occ;
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 16'd0;
        end else begin
            if (r_state == S_HOLD) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (branch_flag) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with hand-computed expectations per cycle.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        branch_flag;
    logic [31:0] branch_pc;
    logic        launch_flag1;
    logic        launch_flag2;
    logic        imem_ready;
    logic        imem_rvalid;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] fetch_pc;
    logic [1:0]  issue;
    logic        stop;
    logic [2:0]  occupancy;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    fetch_ctrl #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .branch_flag  (branch_flag),
        .branch_pc    (branch_pc),
        .launch_flag1 (launch_flag1),
        .launch_flag2 (launch_flag2),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .fetch_pc     (fetch_pc),
        .issue        (issue),
        .stop         (stop),
        .occupancy    (occupancy)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic br, input logic l1, input logic l2);
        imem_ready   = rdy;
        imem_rvalid  = rv;
        branch_flag  = br;
        launch_flag1 = l1;
        launch_flag2 = l2;
        #2;
    endtask

    initial begin
        rst = 1'b1; branch_flag = 1'b0; branch_pc = 32'h0;
        launch_flag1 = 1'b0; launch_flag2 = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0;
        tick(); tick();

        // reset state
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_pc", fetch_pc, 32'h0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_issue", 32'(issue), 32'd0);
        chk("rst_stop", 32'(stop), 32'd0);
        tick();

        // IDLE cycle, response right after reset is ignored
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("idle_issue", 32'(issue), 32'd0);
        chk("idle_req", 32'(imem_req), 32'd0);
        tick();

        // first fetch at 0x0
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("req0_req", 32'(imem_req), 32'd1);
        chk("req0_addr", imem_addr, 32'h0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("wait0_issue", 32'(issue), 32'd3);
        tick();

        // second fetch at 0x8
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("req1_occ", 32'(occupancy), 32'd2);
        chk("req1_req", 32'(imem_req), 32'd1);
        chk("req1_addr", imem_addr, 32'h8);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("wait1_issue", 32'(issue), 32'd3);
        tick();

        // buffer full: HOLD, stray rvalid ignored
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("hold_occ", 32'(occupancy), 32'd4);
        chk("hold_stop", 32'(stop), 32'd1);
        chk("hold_req", 32'(imem_req), 32'd0);
        chk("hold_pc", fetch_pc, 32'h10);
        chk("hold_rv_issue", 32'(issue), 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("hold2_stop", 32'(stop), 32'd1);
        tick();

        // two entries consumed releases the fetch at 0x10; memory stalls 5 cycles
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("stall_occ", 32'(occupancy), 32'd2);
            chk("stall_req", 32'(imem_req), 32'd1);
            chk("stall_addr", imem_addr, 32'h10);
            chk("stall_issue", 32'(issue), 32'd0);
            chk("stall_stop", 32'(stop), 32'd0);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("wait2_issue", 32'(issue), 32'd3);
        tick();

        // occupancy 4 -> 3 with one launch, still no credit (3+2 > 4)
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("c4_occ", 32'(occupancy), 32'd4);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("c3_occ", 32'(occupancy), 32'd3);
        chk("c3_stop", 32'(stop), 32'd1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("c3_nolaunch_stop", 32'(stop), 32'd1);
        tick();
        // 3 - 1 + 2 = 4 permitted
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("c3_launch_req", 32'(imem_req), 32'd1);
        chk("c3_launch_stop", 32'(stop), 32'd0);
        chk("c3_launch_occ", 32'(occupancy), 32'd2);
        chk("c3_launch_addr", imem_addr, 32'h18);
        tick();

        // branch while WAIT without response -> DRAIN
        branch_pc = 32'h104;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("br_issue", 32'(issue), 32'd0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("drain_occ", 32'(occupancy), 32'd0);
        chk("drain_pc", fetch_pc, 32'h104);
        chk("drain_req", 32'(imem_req), 32'd0);
        chk("drain_issue", 32'(issue), 32'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("redir_req", 32'(imem_req), 32'd1);
        chk("redir_addr", imem_addr, 32'h100);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("redir_issue", 32'(issue), 32'd1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("redir_pc", fetch_pc, 32'h108);
        chk("redir_occ", 32'(occupancy), 32'd1);
        chk("redir_addr2", imem_addr, 32'h108);
        tick();

        // branch with rvalid and launch in WAIT: both ignored, straight to REQ
        branch_pc = 32'h200;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("brrv_issue", 32'(issue), 32'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("brrv_occ", 32'(occupancy), 32'd0);
        chk("brrv_pc", fetch_pc, 32'h200);
        chk("brrv_req", 32'(imem_req), 32'd1);
        tick();

        // reset while WAIT, response in reset cycle and the following one
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rstw_issue", 32'(issue), 32'd0);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_rst_issue", 32'(issue), 32'd0);
        chk("post_rst_pc", fetch_pc, 32'h0);
        chk("post_rst_occ", 32'(occupancy), 32'd0);
        chk("post_rst_req", 32'(imem_req), 32'd0);
        chk("post_rst_stop", 32'(stop), 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_req2", 32'(imem_req), 32'd1);
        chk("post_rst_addr", imem_addr, 32'h0);
        chk("post_rst_occ2", 32'(occupancy), 32'd0);
        tick();

`ifdef FETCH_CTRL_PERF_EN
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("perf_rst_stall", stall_cycles, 32'd0);
        chk("perf_rst_flush", 32'(flush_count), 32'd0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        branch_pc = 32'h40;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("perf_stall", stall_cycles, 32'd3);
        chk("perf_flush", 32'(flush_count), 32'd1);
        chk("perf_req", 32'(imem_req), 32'd1);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
REQ-002 Parameter BUF_DEPTH, 4, instruction-buffer entry count tracked by the credit counter.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 branch_flag  input  1  redirect/flush request.
REQ-006 branch_pc  input  32  redirect target, word-aligned.
REQ-007 launch_flag1 / launch_flag2  input  1 each  buffer entries consumed this cycle; consumed = launch_flag2 ? 2 : launch_flag1 ? 1 : 0.
REQ-008 imem_ready  input  1  memory accepts the request this cycle.
REQ-009 imem_rvalid  input  1  fetch data returned this cycle.
REQ-010 imem_req  output  1  fetch request valid.
REQ-011 imem_addr  output  32  8-byte-aligned fetch address, {fetch_pc[31:3],3'b000}.
REQ-012 fetch_pc  output  32  current fetch PC.
REQ-013 issue  output  2  buffer write enables: 2'b11 both words, 2'b01 upper word only, 2'b00 none.
REQ-014 stop  output  1  high while fetch is held for lack of buffer credit.
REQ-015 occupancy  output  3  tracked buffer entries, 0..BUF_DEPTH.

Function
REQ-016 FSM states IDLE, REQ, WAIT, HOLD, DRAIN; at most one request outstanding.
REQ-017 IDLE: lasts one cycle after reset, then goes to REQ if credit allows, else HOLD.
REQ-018 Credit: need = (fetch_pc[2] ? 1 : 2); a request is permitted only when occupancy - consumed + need <= BUF_DEPTH, evaluated with the current cycle's consumption.
REQ-019 REQ: imem_req=1; on imem_ready -> WAIT; imem_addr and fetch_pc stay stable until accepted.
REQ-020 HOLD: imem_req=0, stop=1; -> REQ in the first cycle credit permits.
REQ-021 WAIT: on imem_rvalid, issue=2'b11 if fetch_pc[2]==0, else 2'b01, combinationally in that cycle; fetch_pc advances by 8 (aligned) or 4 (unaligned) to the next 8-byte boundary; next state REQ or HOLD per credit.
REQ-022 issue is 2'b00 in every cycle except a non-discarded rvalid in WAIT.
REQ-023 Occupancy update: occ_next = occ - consumed + popcount(issue); consumed never exceeds occ, and popcount(issue) never exceeds free space.
REQ-024 branch_flag has top priority: occupancy<=0, fetch_pc<=branch_pc, issue=2'b00 that cycle, launch and rvalid in that cycle ignored.
REQ-025 branch_flag in REQ with imem_ready=1, or in WAIT without rvalid: -> DRAIN; the stale response is discarded (issue=2'b00), then -> REQ.
REQ-026 branch_flag in IDLE, HOLD, REQ without ready, or WAIT with rvalid: -> REQ next cycle.
REQ-027 branch_flag in DRAIN: updates fetch_pc, stays DRAIN.
REQ-028 imem_rvalid outside WAIT/DRAIN is ignored.

Reset
REQ-029 On rst: state=IDLE, fetch_pc=RESET_PC, occupancy=0, imem_req=0, issue=2'b00, stop=0, outstanding discard cleared.
REQ-030 rst mid-request overrides all inputs; a response arriving in the cycle after reset is ignored.

Configuration
REQ-031 Macro FETCH_CTRL_PERF_EN: defined adds outputs stall_cycles[31:0] (counts HOLD cycles) and flush_count[15:0] (counts branch_flag cycles); both reset to 0 and wrap.
REQ-032 Without FETCH_CTRL_PERF_EN, those ports and counters are absent; all other behaviour is identical.

Verification
REQ-033 Reset, imem_ready=1, rvalid one cycle after accept, no launches -> addr 0x0 then 0x8; issue=2'b11 twice; occupancy 2 then 4; stop=1; state HOLD.
REQ-034 Continuing REQ-033, launch_flag2=1 one cycle -> occupancy 2; next cycle imem_req=1 with addr 0x10.
REQ-035 branch_flag with branch_pc=0x104 while in WAIT -> occupancy 0; stale rvalid gives issue=2'b00; next addr 0x100; that response gives issue=2'b01; fetch_pc=0x108.
REQ-036 occupancy 3, fetch_pc aligned, launch_flag1=1 in the same cycle -> request permitted (3-1+2=4); with no launch -> HOLD.
REQ-037 imem_ready held low 5 cycles -> imem_req and imem_addr stable throughout; no issue.
REQ-038 FETCH_CTRL_PERF_EN defined, 3 HOLD cycles plus 1 branch -> stall_cycles=3, flush_count=1.
